// File: rtl/vsfx_avg_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vsfx_pkg
// Description : Shared types and constants for the VSFX vector-average unit:
//               opcode encoding, lane widths and vector width, plus small
//               opcode-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package vsfx_pkg;

    localparam int VEC_W    = 32;
    localparam int HALF_W   = 16;
    localparam int BYTE_W   = 8;
    localparam int NUM_HALF = VEC_W / HALF_W;
    localparam int NUM_BYTE = VEC_W / BYTE_W;

    typedef enum logic [1:0] {
        VAVGSH = 2'd0,
        VAVGUH = 2'd1,
        VAVGSB = 2'd2,
        VAVGUB = 2'd3
    } vavg_op_e;

    function automatic logic op_is_byte(input vavg_op_e op);
        return (op == VAVGSB) || (op == VAVGUB);
    endfunction

    function automatic logic op_is_signed(input vavg_op_e op);
        return (op == VAVGSH) || (op == VAVGSB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vsfx_avg_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : vsfx_avg_pipe_if
// Description : Request/response channel bundle of the VSFX average unit.
//               master = issue-side driver (request producer, response sink),
//               slave  = the average unit itself.
// Signals     : in_valid/in_ready/in_op/in_vra/in_vrb/in_tag   request channel
//               out_valid/out_ready/out_vrt/out_tag/out_err     response channel
//               busy                                            pipeline occupied
// Revision    : 1.0 - initial release
// ============================================================================
interface vsfx_avg_pipe_if
    import vsfx_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [VEC_W-1:0]  in_vra;
    logic [VEC_W-1:0]  in_vrb;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [VEC_W-1:0]  out_vrt;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
    logic              busy;

    modport master (
        output in_valid, in_op, in_vra, in_vrb, in_tag, out_ready,
        input  in_ready, out_valid, out_vrt, out_tag, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_vra, in_vrb, in_tag, out_ready,
        output in_ready, out_valid, out_vrt, out_tag, out_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/vsfx_avg_pipe_lane.sv
`default_nettype none
// ============================================================================
// Module      : vavg_lane
// Description : One lane of the rounded average (a+b+1)>>1. Operands are
//               widened by one bit (sign- or zero-extended) so the sum never
//               overflows; dropping the LSB of the widened sum is a floor
//               shift, which for signed lanes is an arithmetic shift.
// Ports       : a_i, b_i  lane operands
//               sgn_i     1 = signed lane, 0 = unsigned lane
//               avg_o     rounded average
// Revision    : 1.0 - initial release
// ============================================================================
module vavg_lane #(
    parameter int W = 16
) (
    input  wire logic [W-1:0] a_i,
    input  wire logic [W-1:0] b_i,
    input  wire logic         sgn_i,
    output logic      [W-1:0] avg_o
);
    logic [W:0] w_a_ext;
    logic [W:0] w_b_ext;
    logic [W:0] w_sum;

    assign w_a_ext = {sgn_i & a_i[W-1], a_i};
    assign w_b_ext = {sgn_i & b_i[W-1], b_i};
    assign w_sum   = w_a_ext + w_b_ext + {{W{1'b0}}, 1'b1};
    assign avg_o   = w_sum[W:1];
endmodule
`default_nettype wire

// File: rtl/vsfx_avg_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vsfx_avg_pipe
// Description : Two-stage elastic vector-average unit. S1 registers the
//               request, lane arithmetic sits between S1 and S2, S2 registers
//               the tagged result. Each stage advances when the stage ahead
//               is empty or is draining, giving one request per cycle with no
//               bubbles and at most two entries held under backpressure.
// Ports       : clk   rising-edge clock
//               rst   asynchronous active-high reset
//               bus   vsfx_avg_pipe_if.slave (request/response channels, busy)
// Config      : VSFX_AVG_BYTE_EN - when defined, byte ops (VAVGSB/VAVGUB)
//               compute byte-lane averages; otherwise they pass through the
//               pipeline and return out_vrt=0 with out_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module vsfx_avg_pipe
    import vsfx_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vsfx_avg_pipe_if.slave   bus
);
    // S1: request operands
    logic              s1_v_q;
    logic [VEC_W-1:0]  s1_a_q;
    logic [VEC_W-1:0]  s1_b_q;
    vavg_op_e          s1_op_q;
    logic [TAG_W-1:0]  s1_tag_q;

    // S2: result
    logic              s2_v_q;
    logic [VEC_W-1:0]  s2_vrt_q;
    logic [VEC_W-1:0]  s2_vrt_d;
    logic [TAG_W-1:0]  s2_tag_q;
    logic              s2_err_q;
    logic              s2_err_d;

    logic              w_s1_load;
    logic              w_s2_load;
    logic              w_sgn;
    logic              w_is_byte;
    logic [VEC_W-1:0]  w_half_res;

    assign w_s2_load = !s2_v_q || bus.out_ready;
    assign w_s1_load = !s1_v_q || w_s2_load;
    assign w_sgn     = op_is_signed(s1_op_q);
    assign w_is_byte = op_is_byte(s1_op_q);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HALF; gi++) begin : g_half
            vavg_lane #(.W(HALF_W)) u_lane (
                .a_i   (s1_a_q[gi*HALF_W +: HALF_W]),
                .b_i   (s1_b_q[gi*HALF_W +: HALF_W]),
                .sgn_i (w_sgn),
                .avg_o (w_half_res[gi*HALF_W +: HALF_W])
            );
        end
    endgenerate

`ifdef VSFX_AVG_BYTE_EN
    logic [VEC_W-1:0]  w_byte_res;

    generate
        for (gi = 0; gi < NUM_BYTE; gi++) begin : g_byte
            vavg_lane #(.W(BYTE_W)) u_lane (
                .a_i   (s1_a_q[gi*BYTE_W +: BYTE_W]),
                .b_i   (s1_b_q[gi*BYTE_W +: BYTE_W]),
                .sgn_i (w_sgn),
                .avg_o (w_byte_res[gi*BYTE_W +: BYTE_W])
            );
        end
    endgenerate

    assign s2_vrt_d = w_is_byte ? w_byte_res : w_half_res;
    assign s2_err_d = 1'b0;
`else
    // Byte ops still occupy a slot so ordering and latency match the full build.
    assign s2_vrt_d = w_is_byte ? '0 : w_half_res;
    assign s2_err_d = w_is_byte;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= VAVGSH;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_vrt_q <= '0;
            s2_tag_q <= '0;
            s2_err_q <= 1'b0;
        end else begin
            if (w_s1_load) begin
                s1_v_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a_q   <= bus.in_vra;
                    s1_b_q   <= bus.in_vrb;
                    s1_op_q  <= vavg_op_e'(bus.in_op);
                    s1_tag_q <= bus.in_tag;
                end
            end
            if (w_s2_load) begin
                s2_v_q <= s1_v_q;
                // Data only moves with a valid entry so idle outputs stay put.
                if (s1_v_q) begin
                    s2_vrt_q <= s2_vrt_d;
                    s2_tag_q <= s1_tag_q;
                    s2_err_q <= s2_err_d;
                end
            end
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = s2_v_q;
    assign bus.out_vrt   = s2_vrt_q;
    assign bus.out_tag   = s2_tag_q;
    assign bus.out_err   = s2_err_q;
    assign bus.busy      = s1_v_q || s2_v_q;
endmodule
`default_nettype wire

// File: tb/tb_vsfx_avg_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_vsfx_avg_pipe
// Description : Self-checking bench for vsfx_avg_pipe: directed vectors,
//               backpressured stream, mid-flight reset and random traffic
//               against a lane-arithmetic reference model and a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vsfx_avg_pipe;
    typedef struct packed {
        logic        err;
        logic [3:0]  tag;
        logic [31:0] vrt;
    } exp_t;

    logic clk;
    logic rst;
    vsfx_avg_pipe_if #(.TAG_W(4)) bus ();

    vsfx_avg_pipe #(.TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t held;
    bit   hold_prev = 0;
    bit   saw_stall = 0;
    int   rcv = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: each lane is read as a signed or unsigned integer and the
    // mathematical floor((x+y+1)/2) is taken, then truncated back to the lane.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
        exp_t        e;
        int          w, x, y, r;
        int unsigned mask;
        logic [31:0] res;
        e.tag = tag;
        e.err = 1'b0;
        w     = op[1] ? 8 : 16;
        mask  = (1 << w) - 1;
        res   = '0;
`ifndef VSFX_AVG_BYTE_EN
        if (op[1]) begin
            e.vrt = '0;
            e.err = 1'b1;
            return e;
        end
`endif
        for (int l = 0; l < 32 / w; l++) begin
            x = int'((a >> (l * w)) & mask);
            y = int'((b >> (l * w)) & mask);
            if (!op[0]) begin
                if (x >= (1 << (w - 1))) x -= (1 << w);
                if (y >= (1 << (w - 1))) y -= (1 << w);
            end
            r   = (x + y + 1) >>> 1;
            res = res | ((32'(r) & mask) << (l * w));
        end
        e.vrt = res;
        return e;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        bus.in_op  = op;
        bus.in_vra = a;
        bus.in_vrb = b;
        bus.in_tag = tag;
        cur_exp    = model(op, a, b, tag);
    endtask

    // Single request on an idle pipe with out_ready high: checks latency and data.
    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] tag,
                            input logic [31:0] exp_vrt, input logic exp_err);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_op = op; bus.in_vra = a; bus.in_vrb = b; bus.in_tag = tag;
        check({name, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({name, "_valid_N"}, bus.out_valid, 0);
        @(posedge clk); #1;
        check({name, "_valid_N1"}, bus.out_valid, 1);
        check({name, "_vrt"}, bus.out_vrt, exp_vrt);
        check({name, "_tag"}, bus.out_tag, tag);
        check({name, "_err"}, bus.out_err, exp_err);
        @(posedge clk); #1;
        check({name, "_drained"}, bus.out_valid, 0);
    endtask

    // One clock of scoreboarded traffic with the current inputs.
    task automatic step(output bit acc_in);
        exp_t e;
        int   occ;
        @(negedge clk);
        occ = sb.size();
        check("in_ready", bus.in_ready, (occ < 2) || bus.out_ready);
        check("busy", bus.busy, occ > 0);
        if (!bus.in_ready) saw_stall = 1;
        if (hold_prev) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", {bus.out_err, bus.out_tag, bus.out_vrt}, held);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("stale_resp", bus.out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("resp", {bus.out_err, bus.out_tag, bus.out_vrt}, e);
                rcv++;
            end
        end
        acc_in = bus.in_valid && bus.in_ready;
        if (acc_in) sb.push_back(cur_exp);
        hold_prev = bus.out_valid && !bus.out_ready;
        held      = {bus.out_err, bus.out_tag, bus.out_vrt};
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_op = '0; bus.in_vra = '0; bus.in_vrb = '0; bus.in_tag = '0;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_vrt", bus.out_vrt, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        directed("sh_a",  2'd0, 32'h7fff_0001, 32'h0001_7ffe, 4'h3, 32'h4000_4000, 1'b0);
        directed("sh_b",  2'd0, 32'h0001_0001, 32'hfedc_ba98, 4'h5, 32'hff6f_dd4d, 1'b0);
        directed("uh_b",  2'd1, 32'h0001_0001, 32'hfedc_ba98, 4'h6, 32'h7f6f_5d4d, 1'b0);
        directed("sh_c",  2'd0, 32'hffff_8000, 32'h0123_4567, 4'h9, 32'h0091_e2b4, 1'b0);
        directed("uh_c",  2'd1, 32'hffff_8000, 32'h0123_4567, 4'ha, 32'h8091_62b4, 1'b0);
`ifdef VSFX_AVG_BYTE_EN
        directed("ub",    2'd3, 32'hff00_ff01, 32'h01ff_0003, 4'hc, 32'h8080_8002, 1'b0);
        directed("sb",    2'd2, 32'h80ff_7f01, 32'h80ff_7f03, 4'hd, 32'h80ff_7f02, 1'b0);
`else
        directed("ub",    2'd3, 32'hff00_ff01, 32'h01ff_0003, 4'hc, 32'h0000_0000, 1'b1);
        directed("sb",    2'd2, 32'h80ff_7f01, 32'h80ff_7f03, 4'hd, 32'h0000_0000, 1'b1);
`endif

        // Stream of 8 with out_ready low for cycles 3..6.
        sent = 0; rcv = 0; saw_stall = 0; hold_prev = 0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            bus.in_valid  = (sent < 8);
            bus.out_ready = !(c >= 3 && c <= 6);
            drive(2'($urandom_range(0, 1)), $urandom, $urandom, 4'(sent));
            step(acc);
            if (acc) sent++;
        end
        check("stream_rcv", 64'(rcv), 8);
        check("stream_sb_empty", 64'(sb.size()), 0);
        check("stream_stall_seen", saw_stall, 1);

        // Reset with two entries in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(2'd0, 32'h1111_2222, 32'h3333_4444, 4'he);
        step(acc);
        drive(2'd1, 32'h5555_6666, 32'h7777_8888, 4'hf);
        step(acc);
        bus.in_valid = 1'b0;
        check("pre_rst_in_ready", bus.in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        sb.delete();
        hold_prev = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("post_rst_no_resp", bus.out_valid, 0);
            step(acc);
        end

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            step(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) step(acc);
        check("final_sb_empty", 64'(sb.size()), 0);
        check("final_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
